// File: rtl/mem_port_arbiter_if.sv
// Bundles the two requester ports and the memory-side bus of the
// unified instruction/data RAM arbiter.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // data-path requester (load/store)
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    // instruction-fetch requester (read only)
    logic                  m1_req;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  stall_if;

    // single-port memory side
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_addr,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata, stall_if,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // environment side: the core's requesters plus the memory
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_addr,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata, stall_if,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the data path (m0, fixed priority)
// and instruction fetch (m1). A starvation counter forces one m1 win after
// STARVE_LIMIT consecutive denials. Reads return exactly one cycle after
// the grant, tagged by the owner register.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t                owner;
    owner_t                owner_nxt;
    logic [CNT_WIDTH-1:0]  wait_cnt;
    logic [CNT_WIDTH-1:0]  wait_cnt_nxt;
    logic                  starve;
    logic                  m0_gnt_c;
    logic                  m1_gnt_c;
    logic                  stall_c;
    logic                  mem_en_c;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    logic                  m0_rvalid_p1;
    logic                  m1_rvalid_p1;
    logic [DATA_WIDTH-1:0] m0_rdata_p1;
    logic [DATA_WIDTH-1:0] m1_rdata_p1;

    // Grant selection, memory drive, next owner and next starvation count.
    // Everything is forced idle while reset is asserted so the memory sees
    // no strobe even though reset is asynchronous.
    always_comb begin
        starve       = (wait_cnt == STARVE_MAX);
        m0_gnt_c     = 1'b0;
        m1_gnt_c     = 1'b0;
        stall_c      = 1'b0;
        mem_en_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        owner_nxt    = OWN_NONE;
        wait_cnt_nxt = '0;

        if (rst_n) begin
            if (bus.m1_req && (!bus.m0_req || starve)) begin
                m1_gnt_c = 1'b1;
            end else if (bus.m0_req) begin
                m0_gnt_c = 1'b1;
            end

            stall_c = bus.m1_req && !m1_gnt_c;

            if (m0_gnt_c) begin
                mem_en_c    = 1'b1;
                mem_we_c    = bus.m0_we;
                mem_addr_c  = bus.m0_addr;
                mem_wdata_c = bus.m0_wdata;
            end else if (m1_gnt_c) begin
                mem_en_c    = 1'b1;
                mem_addr_c  = bus.m1_addr;
            end

            // a write completes at grant, so it leaves no response owner
            if (m0_gnt_c && !bus.m0_we) begin
                owner_nxt = OWN_M0;
            end else if (m1_gnt_c) begin
                owner_nxt = OWN_M1;
            end

            // count consecutive fetch denials, saturating at the limit
            if (stall_c) begin
                wait_cnt_nxt = starve ? wait_cnt : wait_cnt + 1'b1;
            end
        end
    end

    // Response owner, starvation counter and registered read-valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= OWN_NONE;
            wait_cnt     <= '0;
            m0_rvalid_p1 <= 1'b0;
            m1_rvalid_p1 <= 1'b0;
        end else begin
            owner        <= owner_nxt;
            wait_cnt     <= wait_cnt_nxt;
            m0_rvalid_p1 <= (owner_nxt == OWN_M0);
            m1_rvalid_p1 <= (owner_nxt == OWN_M1);
        end
    end

    // Capture memory read data into the owning master's holding register;
    // the other master's register is left untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rdata_p1 <= '0;
            m1_rdata_p1 <= '0;
        end else begin
            if (owner == OWN_M0) begin
                m0_rdata_p1 <= bus.mem_rdata;
            end
            if (owner == OWN_M1) begin
                m1_rdata_p1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.m0_gnt    = m0_gnt_c;
    assign bus.m1_gnt    = m1_gnt_c;
    assign bus.stall_if  = stall_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

    assign bus.m0_rvalid = m0_rvalid_p1;
    assign bus.m1_rvalid = m1_rvalid_p1;

    // during the owner's response cycle the memory word is passed straight
    // through so data and rvalid line up; afterwards the held copy is shown
    assign bus.m0_rdata  = (owner == OWN_M0) ? bus.mem_rdata : m0_rdata_p1;
    assign bus.m1_rdata  = (owner == OWN_M1) ? bus.mem_rdata : m1_rdata_p1;

endmodule
